// File: rtl/hd_pair_gen_if.sv
// ---------------------------------------------------------------------------
// hd_pair_gen_if
// Output stream bundle between the Hamming-distance pair generator and the
// consumer (normally the mhd_mit miter or a bench).
//
// Signals:
//   out_valid  - producer has a pair on a/b/out_hd/exp_f
//   out_ready  - consumer takes the current pair this cycle
//   a, b       - operand pair, popcount(a ^ b) == out_hd
//   out_hd     - Hamming distance of the current pair
//   exp_f      - verdict the miter must produce for this pair
//
// Modports:
//   master - generator side (drives the pair, samples out_ready)
//   slave  - consumer side
// ---------------------------------------------------------------------------
interface hd_pair_gen_if #(
  parameter int WIDTH = 64,
  parameter int LOG2W = 6
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [LOG2W:0]   out_hd;
  logic             exp_f;

  modport master (
    output out_valid,
    output a,
    output b,
    output out_hd,
    output exp_f,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  a,
    input  b,
    input  out_hd,
    input  exp_f,
    output out_ready
  );
endinterface

// File: rtl/hd_pair_gen.sv
// ---------------------------------------------------------------------------
// hd_pair_gen
// Stimulus source for the Hamming-distance miter. Emits a run of operand
// pairs (a, b) whose Hamming distance is exactly k, plus the verdict
// exp_f = (k > MHD). Operand a comes from a 64-bit LFSR; b = a ^ mask where
// mask is a weight-k thermometer rotated left by the top LOG2W LFSR bits.
//
// Ports:
//   clk        - clock, all state on rising edge
//   rst_n      - asynchronous active-low reset
//   start      - one-cycle run request, only honoured in IDLE
//   seed       - LFSR seed (zero is replaced by 1), captured on start
//   target_hd  - initial distance k, clamped to WIDTH, captured on start
//   sweep      - when set, k steps up (wrapping WIDTH -> 0) per accepted pair
//   count      - number of pairs in the run, captured on start
//   out_if     - pair stream (valid/ready), master side
//   busy       - high while pairs are being offered
//   done       - one-cycle pulse after the last pair (or after a count=0 start)
// ---------------------------------------------------------------------------
module hd_pair_gen #(
  parameter int WIDTH = 64,
  parameter int LOG2W = 6,
  parameter int MHD   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [63:0]       seed,
  input  logic [LOG2W:0]    target_hd,
  input  logic              sweep,
  input  logic [15:0]       count,
  hd_pair_gen_if.master     out_if,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  localparam logic [LOG2W:0] WIDTH_K = (LOG2W+1)'(WIDTH);
  localparam logic [LOG2W:0] MHD_K   = (LOG2W+1)'(MHD);

  state_t           state;
  logic [63:0]      lfsr;
  logic [LOG2W:0]   k;
  logic [15:0]      rem;
  logic             sweep_q;
  logic             valid_q;

  logic [LOG2W:0]   target_clamped;
  logic [63:0]      lfsr_next;
  logic             fire;
  logic [LOG2W-1:0] rot;
  logic [LOG2W:0]   rot_comp;
  logic [WIDTH-1:0] therm;
  logic [WIDTH-1:0] mask;

  assign target_clamped = (target_hd > WIDTH_K) ? WIDTH_K : target_hd;
  assign lfsr_next      = {lfsr[62:0], lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59]};
  assign fire           = valid_q && out_if.out_ready;

  // Control FSM. out_valid/busy/done are registered alongside the state so
  // they change only on the edge that changes the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lfsr    <= 64'h1;
      k       <= '0;
      rem     <= '0;
      sweep_q <= 1'b0;
      valid_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            lfsr    <= (seed == 64'h0) ? 64'h1 : seed;
            k       <= target_clamped;
            rem     <= count;
            sweep_q <= sweep;
            if (count == 16'h0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state   <= RUN;
              valid_q <= 1'b1;
              busy    <= 1'b1;
            end
          end
        end
        RUN: begin
          if (fire) begin
            lfsr <= lfsr_next;
            if (sweep_q) begin
              k <= (k == WIDTH_K) ? '0 : k + (LOG2W+1)'(1);
            end
            rem <= rem - 16'h1;
            if (rem == 16'h1) begin
              state   <= FIN;
              valid_q <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  // Weight-k thermometer, rotated left by the top LOG2W LFSR bits. A right
  // shift by WIDTH (rotation 0) yields zero, so the OR is a clean rotate.
  always_comb begin
    rot      = lfsr[63:64-LOG2W];
    rot_comp = WIDTH_K - {1'b0, rot};
    if (k >= WIDTH_K) begin
      therm = '1;
    end else begin
      therm = ~({WIDTH{1'b1}} << k);
    end
    mask = (therm << rot) | (therm >> rot_comp);
  end

  // Pair outputs are gated by out_valid so they read zero outside RUN.
  always_comb begin
    out_if.out_valid = valid_q;
    out_if.a         = '0;
    out_if.b         = '0;
    out_if.out_hd    = '0;
    out_if.exp_f     = 1'b0;
    if (valid_q) begin
      out_if.a      = lfsr[WIDTH-1:0];
      out_if.b      = lfsr[WIDTH-1:0] ^ mask;
      out_if.out_hd = k;
      out_if.exp_f  = (k > MHD_K);
    end
  end

endmodule

// File: tb/tb_hd_pair_gen.sv
// ---------------------------------------------------------------------------
// tb_hd_pair_gen
// Scoreboard bench for hd_pair_gen. Each run's expected pairs are computed
// from the LFSR / rotated-mask rules and queued when the run is started; a
// monitor pops and compares on every accepted transfer, checks stall
// stability, and checks the done pulse after the last pair.
// ---------------------------------------------------------------------------
module tb_hd_pair_gen;
  localparam int WIDTH = 64;
  localparam int LOG2W = 6;
  localparam int MHD   = 32;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int               hd;
    logic             f;
  } pair_t;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [63:0]    seed;
  logic [LOG2W:0] target_hd;
  logic           sweep;
  logic [15:0]    count;
  logic           busy;
  logic           done;

  hd_pair_gen_if #(.WIDTH(WIDTH), .LOG2W(LOG2W)) out_if ();

  hd_pair_gen #(.WIDTH(WIDTH), .LOG2W(LOG2W), .MHD(MHD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .seed      (seed),
    .target_hd (target_hd),
    .sweep     (sweep),
    .count     (count),
    .out_if    (out_if),
    .busy      (busy),
    .done      (done)
  );

  pair_t            expQ[$];
  int               vectors;
  int               miscompares;
  int               pops;
  bit               expectDone;
  bit               randomReady;
  bit               holdValid;
  logic [WIDTH-1:0] heldA;
  logic [WIDTH-1:0] heldB;
  logic [LOG2W:0]   heldHd;
  logic             heldF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Reference model: walks the LFSR and places k set bits starting at the
  // rotation position, then issues the start request.
  task automatic applyStimulus(input logic [63:0] s, input int tgt,
                               input bit sw, input int cnt);
    logic [63:0]      l;
    logic [WIDTH-1:0] m;
    int               kk;
    int               r;
    pair_t            p;
    l  = (s == 64'h0) ? 64'h1 : s;
    kk = (tgt > WIDTH) ? WIDTH : tgt;
    for (int n = 0; n < cnt; n++) begin
      r = int'(l[63:64-LOG2W]);
      m = '0;
      for (int i = 0; i < kk; i++) m[(r + i) % WIDTH] = 1'b1;
      p.a  = l[WIDTH-1:0];
      p.b  = l[WIDTH-1:0] ^ m;
      p.hd = kk;
      p.f  = (kk > MHD);
      expQ.push_back(p);
      l  = {l[62:0], l[63] ^ l[62] ^ l[60] ^ l[59]};
      if (sw) kk = (kk == WIDTH) ? 0 : kk + 1;
    end
    @(negedge clk);
    seed      = s;
    target_hd = 7'(tgt);
    sweep     = sw;
    count     = 16'(cnt);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (cnt == 0) expectDone = 1'b1;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (!(expQ.size() == 0 && !expectDone && !done && !busy && !out_if.out_valid)) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        checkOutput("run_timeout", 64'h1, 64'h0);
        expQ.delete();
        expectDone = 1'b0;
        break;
      end
    end
    @(negedge clk);
  endtask

  // Consumer ready: held high, or randomised each cycle when requested.
  initial begin
    out_if.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_if.out_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: done pulse, stall stability and scoreboard compare.
  always @(negedge clk) begin
    if (!rst_n) begin
      holdValid = 1'b0;
    end else begin
      if (done || expectDone) begin
        checkOutput("done_pulse", 64'(done), 64'(expectDone));
        if (done) checkOutput("done_queue_empty", 64'(expQ.size()), 64'h0);
        expectDone = 1'b0;
      end
      if (out_if.out_valid) begin
        if (holdValid) begin
          checkOutput("stall_a", out_if.a, heldA);
          checkOutput("stall_b", out_if.b, heldB);
          checkOutput("stall_hd", 64'(out_if.out_hd), 64'(heldHd));
          checkOutput("stall_f", 64'(out_if.exp_f), 64'(heldF));
        end
        if (out_if.out_ready) begin
          holdValid = 1'b0;
          if (expQ.size() == 0) begin
            checkOutput("extra_pair", 64'h1, 64'h0);
          end else begin
            pair_t p;
            p = expQ.pop_front();
            pops++;
            checkOutput("pair_a", out_if.a, p.a);
            checkOutput("pair_b", out_if.b, p.b);
            checkOutput("pair_hd", 64'(out_if.out_hd), 64'(p.hd));
            checkOutput("pair_exp_f", 64'(out_if.exp_f), 64'(p.f));
            checkOutput("pair_popcount", 64'($countones(out_if.a ^ out_if.b)), 64'(p.hd));
            checkOutput("busy_in_run", 64'(busy), 64'h1);
            if (expQ.size() == 0) expectDone = 1'b1;
          end
        end else begin
          holdValid = 1'b1;
          heldA     = out_if.a;
          heldB     = out_if.b;
          heldHd    = out_if.out_hd;
          heldF     = out_if.exp_f;
        end
      end else begin
        holdValid = 1'b0;
      end
    end
  end

  initial begin
    logic [63:0] s;
    int          startPops;
    int          n;
    vectors     = 0;
    miscompares = 0;
    pops        = 0;
    expectDone  = 1'b0;
    randomReady = 1'b0;
    holdValid   = 1'b0;
    rst_n       = 1'b0;
    start       = 1'b0;
    seed        = '0;
    target_hd   = '0;
    sweep       = 1'b0;
    count       = '0;

    #1;
    checkOutput("reset_out_valid", 64'(out_if.out_valid), 64'h0);
    checkOutput("reset_busy", 64'(busy), 64'h0);
    checkOutput("reset_done", 64'(done), 64'h0);
    checkOutput("reset_a", out_if.a, 64'h0);
    checkOutput("reset_b", out_if.b, 64'h0);
    checkOutput("reset_out_hd", 64'(out_if.out_hd), 64'h0);
    checkOutput("reset_exp_f", 64'(out_if.exp_f), 64'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic run, seed=1 k=1 count=2");
    applyStimulus(64'h1, 1, 1'b0, 2);
    waitIdle();

    $display("[TB] zero seed, full weight");
    applyStimulus(64'h0, 64, 1'b0, 1);
    waitIdle();

    $display("[TB] sweep across the threshold");
    applyStimulus(64'hDEAD_BEEF_1234_5678, 31, 1'b1, 4);
    waitIdle();

    $display("[TB] clamp of target_hd above WIDTH with sweep wrap");
    applyStimulus(64'h0BAD_F00D_CAFE_0001, 100, 1'b1, 5);
    waitIdle();

    $display("[TB] 100 pairs, ready high then random, start during run");
    s = {$urandom, $urandom};
    applyStimulus(s, 5, 1'b0, 100);
    waitIdle();
    randomReady = 1'b1;
    applyStimulus(s, 5, 1'b0, 100);
    repeat (20) @(negedge clk);
    seed      = ~s;
    target_hd = 7'd60;
    sweep     = 1'b1;
    count     = 16'd3;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitIdle();
    randomReady = 1'b0;

    $display("[TB] count of zero");
    applyStimulus(64'h5, 3, 1'b0, 0);
    waitIdle();

    $display("[TB] reset in the middle of a run");
    s = 64'h1357_9BDF_2468_ACE0;
    startPops = pops;
    applyStimulus(s, 10, 1'b0, 10);
    n = 0;
    while (pops < startPops + 3 && n < 200) begin
      @(posedge clk);
      n++;
    end
    checkOutput("reset_wait_pops", 64'(pops - startPops >= 3), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_reset_valid", 64'(out_if.out_valid), 64'h0);
    checkOutput("midrun_reset_busy", 64'(busy), 64'h0);
    expQ.delete();
    expectDone = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("midrun_reset_done", 64'(done), 64'h0);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("post_reset_idle_done", 64'(done), 64'h0);
      checkOutput("post_reset_idle_valid", 64'(out_if.out_valid), 64'h0);
    end
    applyStimulus(s, 10, 1'b0, 10);
    waitIdle();

    $display("[TB] random runs");
    for (int t = 0; t < 8; t++) begin
      randomReady = 1'($urandom_range(0, 1));
      applyStimulus({$urandom, $urandom}, $urandom_range(0, 70),
                    1'($urandom_range(0, 1)), $urandom_range(1, 30));
      waitIdle();
    end
    randomReady = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
